// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths, loader state type and index-width helper for the matrix datapath.
package matrix_pkg;
  localparam int ELEM_W = 20;
  localparam int PROD_W = 40;
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} ld_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/matrix_index_counter.sv
// matrix_index_counter: row-major row/col walker with run-time limits so one instance serves both matrices.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  localparam int RW = idx_w(ROWS),
  localparam int CW = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [RW-1:0] row_lim,
  input  logic [CW-1:0] col_lim,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);
  assign last = (row == row_lim) && (col == col_lim);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      col <= (col == col_lim) ? '0 : col + 1'b1;
      row <= (col == col_lim) ? row + 1'b1 : row;
    end
endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: streams row-major elements into registered matrices A then B for the multiplier.
// Optional MATRIX_LOADER_ABORT_EN adds an abort input that drops an in-progress load.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int aRow = 2,
  parameter int aCol = 2,
  parameter int bRow = 2,
  parameter int bCol = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MATRIX_LOADER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ELEM_W-1:0] a [0:aRow-1][0:aCol-1],
  output logic [ELEM_W-1:0] b [0:bRow-1][0:bCol-1],
  output logic              load_done,
  output logic              busy
);
  localparam int RW = idx_w(aRow > bRow ? aRow : bRow);
  localparam int CW = idx_w(aCol > bCol ? aCol : bCol);
  if (bRow != aCol) begin : g_dim_err
    $error("matrix_loader: bRow must equal aCol");
  end
  ld_state_t     state, nxt;
  logic          accept, last, kill, go;
  logic [RW-1:0] row, row_lim;
  logic [CW-1:0] col, col_lim;
  assign busy      = (state == LOAD_A) || (state == LOAD_B);
  assign in_ready  = busy;
  assign load_done = (state == DONE);
`ifdef MATRIX_LOADER_ABORT_EN
  assign kill = abort && busy;
`else
  assign kill = 1'b0;
`endif
  // an abort on the same edge as a handshake wins, so the element is dropped
  assign accept  = in_valid && in_ready && !kill;
  assign go      = start && !busy;
  assign row_lim = (state == LOAD_B) ? RW'(bRow - 1) : RW'(aRow - 1);
  assign col_lim = (state == LOAD_B) ? CW'(bCol - 1) : CW'(aCol - 1);
  always_comb
    nxt = kill ? IDLE :
          go ? LOAD_A :
          (accept && last) ? ((state == LOAD_A) ? LOAD_B : DONE) : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  matrix_index_counter #(
    .ROWS(aRow > bRow ? aRow : bRow),
    .COLS(aCol > bCol ? aCol : bCol)
  ) u_idx (
    .clk(clk),
    .rst(rst),
    .clr(go || kill || (accept && last)),
    .inc(accept),
    .row_lim(row_lim),
    .col_lim(col_lim),
    .row(row),
    .col(col),
    .last(last)
  );
  for (genvar i = 0; i < aRow; i++) begin : g_ar
    for (genvar j = 0; j < aCol; j++) begin : g_ac
      always_ff @(posedge clk or posedge rst)
        if (rst) a[i][j] <= '0;
        else if (accept && state == LOAD_A && row == RW'(i) && col == CW'(j)) a[i][j] <= in_data;
    end
  end
  for (genvar i = 0; i < bRow; i++) begin : g_br
    for (genvar j = 0; j < bCol; j++) begin : g_bc
      always_ff @(posedge clk or posedge rst)
        if (rst) b[i][j] <= '0;
        else if (accept && state == LOAD_B && row == RW'(i) && col == CW'(j)) b[i][j] <= in_data;
    end
  end
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed checks of the default 2x2 loader plus a 1x3 / 3x1 instance.
module tb_matrix_loader;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, in_valid = 1'b0, in_ready, load_done, busy;
  logic [19:0] in_data = '0;
  logic [19:0] a [0:1][0:1];
  logic [19:0] b [0:1][0:1];
  logic        s1 = 1'b0, v1 = 1'b0, r1, d1, bz1;
  logic [19:0] x1 = '0;
  logic [19:0] a1 [0:0][0:2];
  logic [19:0] b1 [0:2][0:0];
`ifdef MATRIX_LOADER_ABORT_EN
  logic        abort = 1'b0;
`endif
  int ncmp = 0, nfail = 0;
  always #5 clk = ~clk;
  matrix_loader dut (
    .clk(clk), .rst(rst),
`ifdef MATRIX_LOADER_ABORT_EN
    .abort(abort),
`endif
    .start(start), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .load_done(load_done), .busy(busy)
  );
  matrix_loader #(.aRow(1), .aCol(3), .bRow(3), .bCol(1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef MATRIX_LOADER_ABORT_EN
    .abort(1'b0),
`endif
    .start(s1), .in_data(x1), .in_valid(v1), .in_ready(r1),
    .a(a1), .b(b1), .load_done(d1), .busy(bz1)
  );
  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", t, obs, exp);
    end
  endtask
  task automatic chk_ab(input string t, input logic [7:0][19:0] e);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("%s_a%0d%0d", t, i, j), 32'(a[i][j]), 32'(e[7 - (i * 2 + j)]));
        chk($sformatf("%s_b%0d%0d", t, i, j), 32'(b[i][j]), 32'(e[3 - (i * 2 + j)]));
      end
  endtask
  task automatic flags(input string t, input logic rdy, input logic bz, input logic dn);
    chk({t, "_ready"}, 32'(in_ready), 32'(rdy));
    chk({t, "_busy"}, 32'(busy), 32'(bz));
    chk({t, "_done"}, 32'(load_done), 32'(dn));
  endtask
  task automatic cyc(input logic st, input logic vl, input logic [19:0] d);
    start = st; in_valid = vl; in_data = d;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1; #1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #1;
    flags("rst", 0, 0, 0);
    chk_ab("rst", '0);
    @(negedge clk); rst = 1'b0;
    // full load with in_valid held high
    cyc(1, 0, 0);
    flags("start", 1, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 20'(k));
      chk($sformatf("done_after_%0d", k), 32'(load_done), 32'(k == 8));
    end
    chk_ab("stream", {20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8});
    flags("done", 0, 0, 1);
    cyc(0, 1, 20'd77);
    chk_ab("drop_in_done", {20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8});
    // gapped stream: idle cycles carry junk data that must not land
    do_reset();
    chk_ab("rst2", '0);
    cyc(1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 1, 20'(k));
      cyc(0, 0, 20'd99);
    end
    chk_ab("gapped", {20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8});
    chk("gapped_done", 32'(load_done), 32'd1);
    // reset mid-load, then no start
    cyc(1, 0, 0);
    cyc(0, 1, 20'd21); cyc(0, 1, 20'd22); cyc(0, 1, 20'd23);
    rst = 1'b1; #1;
    flags("async_rst", 0, 0, 0);
    chk_ab("async_rst", '0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 20'd5);
      flags($sformatf("nostart%0d", k), 0, 0, 0);
    end
    chk("nostart_a00", 32'(a[0][0]), 32'd0);
    // start during LOAD_B is ignored, then reload from DONE
    cyc(1, 0, 0);
    for (int k = 1; k <= 4; k++) cyc(0, 1, 20'(k));
    cyc(1, 1, 20'd5);
    flags("startB", 1, 1, 0);
    for (int k = 6; k <= 8; k++) cyc(0, 1, 20'(k));
    chk_ab("ignB", {20'd1, 20'd2, 20'd3, 20'd4, 20'd5, 20'd6, 20'd7, 20'd8});
    chk("ignB_done", 32'(load_done), 32'd1);
    cyc(1, 0, 0);
    flags("restart", 1, 1, 0);
    for (int k = 9; k <= 16; k++) begin
      cyc(0, 1, 20'(k));
      chk($sformatf("reload_done_%0d", k), 32'(load_done), 32'(k == 16));
    end
    chk_ab("reload", {20'd9, 20'd10, 20'd11, 20'd12, 20'd13, 20'd14, 20'd15, 20'd16});
    // non-square instance
    s1 = 1'b1; @(negedge clk); s1 = 1'b0;
    chk("ns_ready", 32'(r1), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      v1 = 1'b1; x1 = 20'(k); @(negedge clk); v1 = 1'b0;
      chk($sformatf("ns_done_%0d", k), 32'(d1), 32'(k == 6));
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ns_a0%0d", k), 32'(a1[0][k]), 32'(k + 1));
      chk($sformatf("ns_b%0d0", k), 32'(b1[k][0]), 32'(k + 4));
    end
    chk("ns_busy", 32'(bz1), 32'd0);
`ifdef MATRIX_LOADER_ABORT_EN
    do_reset();
    cyc(1, 0, 0);
    cyc(0, 1, 20'd1);
    abort = 1'b1; cyc(0, 1, 20'd2); abort = 1'b0;
    flags("abort", 0, 0, 0);
    chk("abort_a00", 32'(a[0][0]), 32'd1);
    chk("abort_a01", 32'(a[0][1]), 32'd0);
    abort = 1'b1; cyc(0, 1, 20'd3); abort = 1'b0;
    flags("abort_idle", 0, 0, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
